// File: rtl/cut_arbiter_if.sv
// Handshake bundle for cut_arbiter: two requester ports plus the result drain port.
// The master modport is the requester/consumer side; slave is the arbiter.
interface cut_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [5:0]  a_n;
  logic [31:0] a_in;
  logic        b_valid;
  logic        b_ready;
  logic [5:0]  b_n;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_src;
  logic        busy;

  modport master (
    output a_valid, a_n, a_in, b_valid, b_n, b_in, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src, busy
  );

  modport slave (
    input  a_valid, a_n, a_in, b_valid, b_n, b_in, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/cut_arbiter.sv
// Round-robin sharing of one 32-bit truncation unit between two requesters;
// results are queued with their source tag and drained over valid/ready.
module cut_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  cut_arbiter_if.slave  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          last_grant_q, last_grant_d;

  logic [31:0]   data_mem_q [FIFO_DEPTH];
  logic          src_mem_q  [FIFO_DEPTH];

  logic          space;
  logic          grant_a;
  logic          grant_b;
  logic          push;
  logic          pop;
  logic          sel_src;
  logic [5:0]    sel_n;
  logic [31:0]   sel_in;
  logic [31:0]   cut_mask;
  logic [31:0]   cut_out;

  // Bit gi survives when the width exceeds gi; widths >= 32 keep every bit.
  for (genvar gi = 0; gi < 32; gi++) begin : g_mask
    assign cut_mask[gi] = (sel_n > 6'(gi));
  end
  assign cut_out = sel_in & cut_mask;

  always_comb begin
    // Space comes from the registered count only, so ready never sees out_ready.
    space   = (count_q < DEPTH_C);
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n && space) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_a = (last_grant_q == SRC_B);
        grant_b = !grant_a;
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end

    push    = grant_a | grant_b;
    sel_src = grant_b ? SRC_B : SRC_A;
    sel_n   = grant_b ? bus.b_n  : bus.a_n;
    sel_in  = grant_b ? bus.b_in : bus.a_in;
    pop     = (count_q != '0) && bus.out_ready;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    last_grant_d = push ? sel_src : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_grant_q <= SRC_B;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Storage is not reset; entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= cut_out;
      src_mem_q[wr_ptr_q]  <= sel_src;
    end
  end

  assign bus.a_ready   = grant_a;
  assign bus.b_ready   = grant_b;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = data_mem_q[rd_ptr_q];
  assign bus.out_src   = src_mem_q[rd_ptr_q];
  assign bus.busy      = (count_q != '0) | bus.a_valid | bus.b_valid;

endmodule

// File: tb/tb_cut_arbiter.sv
// Bench for cut_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference of the arbiter and result FIFO.
module tb_cut_arbiter;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cut_arbiter_if bus ();

  cut_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        src;
    logic [31:0] data;
  } res_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t mdl_q[$];
  logic mdl_last = 1'b1;
  logic exp_ga;
  logic exp_gb;

  function automatic logic [31:0] cut_ref(logic [5:0] n, logic [31:0] x);
    logic [63:0] w;
    if (n >= 6'd32) return x;
    w = 64'(x) % (64'd1 << n);
    return w[31:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock with the inputs already driven: check outputs, then advance the model.
  task automatic cycle();
    logic        ga, gb, pop;
    logic [31:0] res;
    res_t        r;
    #1;
    ga = 1'b0;
    gb = 1'b0;
    if (rst_n && mdl_q.size() < DEPTH) begin
      if (bus.a_valid && bus.b_valid) begin
        if (mdl_last) ga = 1'b1;
        else          gb = 1'b1;
      end else begin
        ga = bus.a_valid;
        gb = bus.b_valid;
      end
    end
    exp_ga = ga;
    exp_gb = gb;
    check_eq("a_ready", bus.a_ready, ga);
    check_eq("b_ready", bus.b_ready, gb);
    check_eq("out_valid", bus.out_valid, mdl_q.size() != 0);
    check_eq("busy", bus.busy, (mdl_q.size() != 0) | bus.a_valid | bus.b_valid);
    if (mdl_q.size() != 0) begin
      check_eq("out_data", bus.out_data, mdl_q[0].data);
      check_eq("out_src", bus.out_src, mdl_q[0].src);
    end
    pop = (mdl_q.size() != 0) && bus.out_ready;
    res = gb ? cut_ref(bus.b_n, bus.b_in) : cut_ref(bus.a_n, bus.a_in);
    @(posedge clk);
    if (!rst_n) begin
      mdl_q.delete();
      mdl_last = 1'b1;
    end else begin
      if (pop) begin
        r = mdl_q.pop_front();
        $display("pop src=%0d data=%h", r.src, r.data);
      end
      if (ga | gb) begin
        mdl_q.push_back('{src: gb, data: res});
        mdl_last = gb;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int cycles);
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  logic [5:0]  sweep_n [7] = '{6'd0, 6'd1, 6'd4, 6'd15, 6'd31, 6'd32, 6'd40};
  logic [31:0] sweep_e [7] = '{32'h0, 32'h1, 32'hF, 32'h7FFF, 32'h7FFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF};

  initial begin
    bus.a_valid   = 1'b1;
    bus.b_valid   = 1'b1;
    bus.a_n       = 6'd8;
    bus.a_in      = 32'h12345678;
    bus.b_n       = 6'd16;
    bus.b_in      = 32'hDEADBEEF;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset held two cycles; the first is unchecked because state is unknown before it.
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    #1;
    check_eq("rst_first_a_ready", bus.a_ready, 1'b1);
    check_eq("rst_first_b_ready", bus.b_ready, 1'b0);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    cycle();
    bus.a_valid = 1'b0;
    cycle();
    drain(3);

    // Tie fairness: A first because the last grant went to B.
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("tie_src", bus.out_src, k[0]);
      check_eq("tie_data", bus.out_data, k[0] ? 32'h0000BEEF : 32'h00000078);
    end
    drain(3);

    // Width sweep, one result per cycle.
    bus.a_valid = 1'b1;
    bus.a_in    = 32'hFFFFFFFF;
    for (int k = 0; k < 7; k++) begin
      bus.a_n = sweep_n[k];
      cycle();
      check_eq("sweep_valid", bus.out_valid, 1'b1);
      check_eq("sweep_data", bus.out_data, sweep_e[k]);
      check_eq("sweep_src", bus.out_src, 1'b0);
    end
    drain(3);

    // Backpressure: fill, then a single pop must not re-open ready that cycle.
    bus.out_ready = 1'b0;
    bus.a_valid   = 1'b1;
    bus.a_n       = 6'd20;
    bus.a_in      = $urandom;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (exp_ga) bus.a_in = $urandom;
    end
    check_eq("bp_full_a_ready", bus.a_ready, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_pop_a_ready", bus.a_ready, 1'b0);
    cycle();
    bus.out_ready = 1'b0;
    #1;
    check_eq("bp_after_pop_a_ready", bus.a_ready, 1'b1);
    cycle();
    drain(4);

    // Steady push and pop with one entry resident.
    bus.a_valid   = 1'b1;
    bus.a_n       = 6'd63;
    bus.a_in      = $urandom;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (exp_ga) bus.a_in = $urandom;
    end
    drain(3);

    // Reset with a full FIFO discards both results.
    bus.out_ready = 1'b0;
    bus.a_valid   = 1'b1;
    bus.a_n       = 6'd12;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (exp_ga) bus.a_in = $urandom;
    end
    bus.b_valid = 1'b1;
    rst_n       = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    check_eq("midrst_out_valid", bus.out_valid, 1'b0);
    check_eq("midrst_a_ready", bus.a_ready, 1'b1);
    check_eq("midrst_b_ready", bus.b_ready, 1'b0);
    cycle();
    bus.a_valid = 1'b0;
    cycle();
    drain(3);

    // Random traffic with occasional reset; requesters hold until accepted.
    for (int i = 0; i < 600; i++) begin
      if (!bus.a_valid && ($urandom_range(9) < 6)) begin
        bus.a_valid = 1'b1;
        bus.a_n     = 6'($urandom_range(63));
        bus.a_in    = $urandom;
      end
      if (!bus.b_valid && ($urandom_range(9) < 6)) begin
        bus.b_valid = 1'b1;
        bus.b_n     = 6'($urandom_range(63));
        bus.b_in    = $urandom;
      end
      bus.out_ready = ($urandom_range(9) < 7);
      rst_n         = ($urandom_range(49) != 0);
      cycle();
      if (exp_ga) bus.a_valid = 1'b0;
      if (exp_gb) bus.b_valid = 1'b0;
    end
    rst_n = 1'b1;
    drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cut_arbiter.md
# cut_arbiter

Shares one CUT_32 bit-truncation datapath between two requesters (A and B) using round-robin arbitration. Accepted operations go through the shared CUT_32 instance. Each result is stored with its source tag in a result FIFO and drained over a valid/ready output port. The block sits between the ALU's operand-issue logic and writeback, so two producers can use one truncation unit without duplicating it.

## Interface
- `FIFO_DEPTH`, default 2: result FIFO entries; power of two, ≥ 2.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `a_valid` input 1: requester A has an operation.
- `a_ready` output 1: requester A's operation is accepted this cycle.
- `a_n` input 6: A's cut width, 0..63.
- `a_in` input 32: A's operand.
- `b_valid`, `b_ready`, `b_n` (6), `b_in` (32): same meaning, for requester B.
- `out_valid` output 1: FIFO head holds a result.
- `out_ready` input 1: consumer takes the head this cycle.
- `out_data` output 32: head result.
- `out_src` output 1: head source; 0 = A, 1 = B.
- `busy` output 1: FIFO non-empty or any `*_valid` high.

## Operation
- **CUT_32 contract:** out = in with bits [31:n] cleared.
  - n = 0 gives 0.
  - n in 1..31 keeps the low n bits.
  - n ≥ 32 passes `in` unchanged.
  - Widths 33..63 are legal and behave as 32.
- **Space:** `space = (count < FIFO_DEPTH)`, evaluated on the registered count only. A pop in the same cycle does not free space, so there is no combinational path from `out_ready` to `*_ready`.
- **Arbitration (combinational per cycle):**
  - If `space` is 0, there is no grant.
  - If only one requester is valid, that one is granted.
  - If both are valid, grant the requester other than `last_grant`.
- **Ready outputs:** `a_ready` = grant to A, `b_ready` = grant to B; never both high. A transfer happens when `valid & ready`.
- **Requester rules:** requesters hold `valid`, `n` and `in` stable until accepted. The arbiter never drops or reorders accepted operations.
- **Accepted operation:** the granted `n`/`in` are muxed into CUT_32, and the result plus `src` are pushed into the FIFO at the same clock edge. `last_grant` updates to the granted source.
- **FIFO:** circular buffer with read/write pointers and a count register 0..FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop when `out_valid & out_ready`.
  - Simultaneous push and pop leaves `count` unchanged; both pointers advance.
  - Pop while empty is ignored.
- **Output:** `out_valid = (count != 0)`. `out_data`/`out_src` come from the head entry and stay stable while `out_valid & !out_ready`.
- **Reset (`rst_n` low at a clock edge):**
  - `count` = 0 and both pointers = 0.
  - `last_grant` = B, so A wins the first tie.
  - `out_valid` = 0, `busy` follows its inputs.
  - `*_ready` = 0 during reset cycles.
  - FIFO contents are discarded, including any mid-stream results. `out_data`/`out_src` are don't-care while `out_valid` = 0.

## Timing
- **Accept to output:** an op accepted at edge t appears at the head with `out_valid` high after edge t if the FIFO was empty. Otherwise it is queued behind earlier results.
- **Throughput:** one operation per cycle while the consumer keeps `out_ready` high and the FIFO is not full.
- **Full FIFO:** when `count = FIFO_DEPTH`, both `*_ready` are 0 for that cycle even if a pop occurs. Acceptance resumes the cycle after the pop.
- **Fairness:** with both requesters continuously valid and no backpressure, grants alternate A, B, A, B…. Neither requester waits more than one accepted op of the other once space exists.
- **Ready dependencies:** `*_ready` depend combinationally only on `a_valid`, `b_valid`, `last_grant` and `count`.

## Test plan
1. **Reset:** hold `rst_n` low 2 cycles with both valids high → `a_ready = b_ready = 0`, `out_valid = 0`. On the first cycle after release: `a_ready = 1`, `b_ready = 0`.
2. **Single requester, n sweep:** A alone, `in = 32'hFFFFFFFF`, n = 0, 1, 4, 15, 31, 32, 40, `out_ready = 1` → `out_data` = 0, 1, F, 7FFF, 7FFFFFFF, FFFFFFFF, FFFFFFFF, each with `out_src = 0`, one result per cycle, each one cycle after acceptance.
3. **Tie fairness:** A (n = 8, in = 32'h12345678) and B (n = 16, in = 32'hDEADBEEF) both held valid for 4 ops → sources A, B, A, B with results 32'h78, 32'hBEEF, 32'h78, 32'hBEEF.
4. **Backpressure, FIFO_DEPTH = 2:**
   - `out_ready = 0` and A streams → 2 accepted, then `a_ready = 0`, `count = 2`.
   - Raise `out_ready` for 1 cycle → head pops, `a_ready` still 0 that cycle, 1 next cycle.
   - Results emerge in order.
5. **Simultaneous push/pop with count = 1 over 6 cycles** → `count` stays 1, pointers wrap correctly, no result lost or duplicated (scoreboard match).
6. **Reset mid-stream:** `count = 2`, assert `rst_n` low for 1 cycle → `out_valid = 0` next cycle, stale results never appear. The first post-reset tie grants A.
